// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared load/store ALU_Control codes, FSM states and access-size decode
package mem_stage_pkg;
  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24;
  localparam logic [5:0] LHU = 6'h25, SB = 6'h28, SH = 6'h29, SW = 6'h2B;
  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;
  function automatic size_t op_size(input logic [5:0] c);
    return (c == LB || c == LBU || c == SB) ? SZ_BYTE :
           (c == LH || c == LHU || c == SH) ? SZ_HALF : SZ_WORD;
  endfunction
  function automatic logic op_unsigned(input logic [5:0] c);
    return c == LBU || c == LHU;
  endfunction
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory request/acknowledge bus between mem_stage and the data memory
interface mem_stage_if;
  logic dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0] dmem_be;
  modport master(output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, input dmem_rdata, dmem_ack);
  modport slave(input dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, output dmem_rdata, dmem_ack);
endinterface

// File: rtl/mem_align.sv
// mem_align: byte-lane select, store replication, load extraction and misalignment detect
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [5:0]  alu_ctrl,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misalign
);
  size_t sz;
  logic uns;
  logic [31:0] sh;
  always_comb begin
    sz = op_size(alu_ctrl);
    uns = op_unsigned(alu_ctrl);
    sh = rdata >> {addr_lo, 3'b000};
    misalign = (sz == SZ_HALF && addr_lo[0]) || (sz == SZ_WORD && addr_lo != 2'b00);
    be = sz == SZ_BYTE ? 4'b0001 << addr_lo : sz == SZ_HALF ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata = sz == SZ_BYTE ? {4{store_data[7:0]}} : sz == SZ_HALF ? {2{store_data[15:0]}} : store_data;
    load_data = sz == SZ_BYTE ? {{24{sh[7] & ~uns}}, sh[7:0]} :
                sz == SZ_HALF ? {{16{sh[15] & ~uns}}, sh[15:0]} : rdata;
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage with IDLE/WAIT data-memory FSM and WB registers.
// Define MEM_FORWARDING_EN to add the MEM->EXE bypass ports.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr1_IN,
  input  logic [31:0] Instr1_PC_IN,
  input  logic [31:0] ALU_result1_IN,
  input  logic [4:0]  WriteRegister1_IN,
  input  logic [31:0] MemWriteData1_IN,
  input  logic        RegWrite1_IN,
  input  logic [5:0]  ALU_Control1_IN,
  input  logic        MemRead1_IN,
  input  logic        MemWrite1_IN,
  mem_stage_if.master dmem,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr1_PC_OUT,
  output logic [31:0] WriteData1_OUT,
  output logic [4:0]  WriteRegister1_OUT,
  output logic        RegWrite1_OUT,
  output logic        STALL_OUT,
  output logic        MisalignFault_OUT
`ifdef MEM_FORWARDING_EN
  ,
  output logic [4:0]  BypassReg1_MEMEXE,
  output logic [31:0] BypassData1_MEMEXE,
  output logic        BypassValid1_MEMEXE
`endif
);
  state_t state;
  logic mem_op, misalign, req;
  logic [3:0] be;
  logic [31:0] wdata, load_data;
  mem_align u_align (
    .alu_ctrl(ALU_Control1_IN), .addr_lo(ALU_result1_IN[1:0]), .store_data(MemWriteData1_IN),
    .rdata(dmem.dmem_rdata), .be(be), .wdata(wdata), .load_data(load_data), .misalign(misalign)
  );
  // upstream holds its inputs while stalled, so the bus stays stable through WAIT
  always_comb begin
    mem_op = MemRead1_IN | MemWrite1_IN;
    req = RESET & (state == WAIT | (mem_op & ~misalign));
    dmem.dmem_req = req;
    dmem.dmem_we = req & MemWrite1_IN;
    dmem.dmem_addr = {ALU_result1_IN[31:2], 2'b00};
    dmem.dmem_be = be;
    dmem.dmem_wdata = wdata;
    STALL_OUT = req & ~dmem.dmem_ack;
  end
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state <= IDLE;
      Instr1_OUT <= '0;
      Instr1_PC_OUT <= '0;
      WriteData1_OUT <= '0;
      WriteRegister1_OUT <= '0;
      RegWrite1_OUT <= 1'b0;
      MisalignFault_OUT <= 1'b0;
    end else begin
      state <= STALL_OUT ? WAIT : IDLE;
      MisalignFault_OUT <= mem_op & misalign;
      RegWrite1_OUT <= ~STALL_OUT & RegWrite1_IN & ~MemWrite1_IN & ~(mem_op & misalign);
      if (!STALL_OUT) begin
        Instr1_OUT <= Instr1_IN;
        Instr1_PC_OUT <= Instr1_PC_IN;
        WriteRegister1_OUT <= WriteRegister1_IN;
        WriteData1_OUT <= (MemRead1_IN & ~misalign) ? load_data : ALU_result1_IN;
      end
    end
`ifdef MEM_FORWARDING_EN
  assign BypassReg1_MEMEXE = WriteRegister1_OUT;
  assign BypassData1_MEMEXE = WriteData1_OUT;
  assign BypassValid1_MEMEXE = RegWrite1_OUT;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors for mem_stage checked against a lane-level behavioural model
module tb_mem_stage;
  import mem_stage_pkg::*;
  logic CLK = 1'b0, RESET;
  logic [31:0] Instr1_IN, Instr1_PC_IN, ALU_result1_IN, MemWriteData1_IN;
  logic [4:0] WriteRegister1_IN;
  logic RegWrite1_IN, MemRead1_IN, MemWrite1_IN;
  logic [5:0] ALU_Control1_IN;
  logic [31:0] Instr1_OUT, Instr1_PC_OUT, WriteData1_OUT;
  logic [4:0] WriteRegister1_OUT;
  logic RegWrite1_OUT, STALL_OUT, MisalignFault_OUT;
`ifdef MEM_FORWARDING_EN
  logic [4:0] BypassReg1_MEMEXE;
  logic [31:0] BypassData1_MEMEXE;
  logic BypassValid1_MEMEXE;
`endif
  int vec = 0, mis = 0;
  mem_stage_if dmem();
  mem_stage dut (
    .CLK(CLK), .RESET(RESET), .Instr1_IN(Instr1_IN), .Instr1_PC_IN(Instr1_PC_IN),
    .ALU_result1_IN(ALU_result1_IN), .WriteRegister1_IN(WriteRegister1_IN),
    .MemWriteData1_IN(MemWriteData1_IN), .RegWrite1_IN(RegWrite1_IN), .ALU_Control1_IN(ALU_Control1_IN),
    .MemRead1_IN(MemRead1_IN), .MemWrite1_IN(MemWrite1_IN), .dmem(dmem.master),
    .Instr1_OUT(Instr1_OUT), .Instr1_PC_OUT(Instr1_PC_OUT), .WriteData1_OUT(WriteData1_OUT),
    .WriteRegister1_OUT(WriteRegister1_OUT), .RegWrite1_OUT(RegWrite1_OUT), .STALL_OUT(STALL_OUT),
    .MisalignFault_OUT(MisalignFault_OUT)
`ifdef MEM_FORWARDING_EN
    , .BypassReg1_MEMEXE(BypassReg1_MEMEXE), .BypassData1_MEMEXE(BypassData1_MEMEXE),
    .BypassValid1_MEMEXE(BypassValid1_MEMEXE)
`endif
  );
  always #5 CLK = ~CLK;

  function automatic int nbytes(input logic [5:0] c);
    return (c == LB || c == LBU || c == SB) ? 1 : (c == LH || c == LHU || c == SH) ? 2 : 4;
  endfunction
  function automatic logic [3:0] m_be(input logic [5:0] c, input logic [31:0] a);
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = i >= int'(a % 4) && i < int'(a % 4) + nbytes(c);
    return b;
  endfunction
  function automatic logic [31:0] m_wdata(input logic [5:0] c, input logic [31:0] d);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % nbytes(c)) +: 8];
    return w;
  endfunction
  function automatic logic [31:0] m_load(input logic [5:0] c, input logic [31:0] a, input logic [31:0] r);
    logic [31:0] v = '0;
    int n = nbytes(c);
    int lo = int'(a % 4);
    for (int k = 0; k < n; k++) v[8*k +: 8] = r[8*(lo+k) +: 8];
    if (c != LBU && c != LHU && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  logic e_mem, e_mis, e_req, e_stall;
  always_comb begin
    e_mem = MemRead1_IN | MemWrite1_IN;
    e_mis = e_mem && (ALU_result1_IN % 32'(nbytes(ALU_Control1_IN))) != 0;
    e_req = RESET && e_mem && !e_mis;
    e_stall = e_req && !dmem.dmem_ack;
  end
  logic [31:0] m_instr, m_pc, m_wd;
  logic [4:0] m_wr;
  logic m_rw, m_mf;
  always @(posedge CLK or negedge RESET)
    if (!RESET) begin
      {m_instr, m_pc, m_wd, m_wr, m_rw, m_mf} <= '0;
    end else begin
      m_mf <= e_mis;
      m_rw <= !e_stall && RegWrite1_IN && !MemWrite1_IN && !e_mis;
      if (!e_stall) begin
        m_instr <= Instr1_IN;
        m_pc <= Instr1_PC_IN;
        m_wr <= WriteRegister1_IN;
        m_wd <= (MemRead1_IN && !e_mis) ? m_load(ALU_Control1_IN, ALU_result1_IN, dmem.dmem_rdata) : ALU_result1_IN;
      end
    end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vec++;
    if (a !== e) begin
      mis++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask
  always @(negedge CLK) begin
    chk("req", 32'(dmem.dmem_req), 32'(e_req));
    chk("we", 32'(dmem.dmem_we), 32'(e_req && MemWrite1_IN));
    chk("stall", 32'(STALL_OUT), 32'(e_stall));
    if (e_req) begin
      chk("addr", dmem.dmem_addr, {ALU_result1_IN[31:2], 2'b00});
      chk("be", 32'(dmem.dmem_be), 32'(m_be(ALU_Control1_IN, ALU_result1_IN)));
      if (MemWrite1_IN) chk("wdata", dmem.dmem_wdata, m_wdata(ALU_Control1_IN, MemWriteData1_IN));
    end
    chk("instr", Instr1_OUT, m_instr);
    chk("pc", Instr1_PC_OUT, m_pc);
    chk("wd", WriteData1_OUT, m_wd);
    chk("wr", 32'(WriteRegister1_OUT), 32'(m_wr));
    chk("rw", 32'(RegWrite1_OUT), 32'(m_rw));
    chk("mf", 32'(MisalignFault_OUT), 32'(m_mf));
`ifdef MEM_FORWARDING_EN
    chk("byp_reg", 32'(BypassReg1_MEMEXE), 32'(m_wr));
    chk("byp_data", BypassData1_MEMEXE, m_wd);
    chk("byp_valid", 32'(BypassValid1_MEMEXE), 32'(m_rw));
`endif
  end

  task automatic nxt;
    @(posedge CLK);
    #2;
  endtask
  task automatic set_op(input logic [5:0] c, input logic r, input logic w, input logic rw,
                        input logic [31:0] a, input logic [31:0] d, input logic [4:0] rg);
    ALU_Control1_IN = c; MemRead1_IN = r; MemWrite1_IN = w; RegWrite1_IN = rw;
    ALU_result1_IN = a; MemWriteData1_IN = d; WriteRegister1_IN = rg;
    Instr1_IN = a ^ 32'hA5A5_0000; Instr1_PC_IN = Instr1_PC_IN + 32'd4;
  endtask
  task automatic nop;
    set_op(6'h00, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask
  task automatic run_load(input logic [5:0] c, input logic [31:0] a, input logic [31:0] r,
                          input int delay, input logic [4:0] rg, input logic [31:0] exp);
    set_op(c, 1'b1, 1'b0, 1'b1, a, 32'h0, rg);
    dmem.dmem_rdata = r; dmem.dmem_ack = 1'b0;
    for (int i = 0; i < delay; i++) nxt();
    dmem.dmem_ack = 1'b1;
    nxt();
    dmem.dmem_ack = 1'b0; nop();
    @(negedge CLK);
    chk("load_wd", WriteData1_OUT, exp);
    chk("load_rw", 32'(RegWrite1_OUT), 32'd1);
  endtask

  initial begin
    RESET = 1'b1; Instr1_PC_IN = 32'h0; dmem.dmem_rdata = '0; dmem.dmem_ack = 1'b0;
    nop();
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk("rst_wd", WriteData1_OUT, 32'h0);
    chk("rst_rw", 32'(RegWrite1_OUT), 32'd0);
    chk("rst_req", 32'(dmem.dmem_req), 32'd0);
    nxt();
    RESET = 1'b1;
    // ALU pass-through
    set_op(6'h00, 1'b0, 1'b0, 1'b1, 32'h1234, 32'h0, 5'd5);
    @(negedge CLK);
    chk("alu_stall", 32'(STALL_OUT), 32'd0);
    nxt();
    nop();
    @(negedge CLK);
    chk("alu_wd", WriteData1_OUT, 32'h1234);
    chk("alu_rw", 32'(RegWrite1_OUT), 32'd1);
    chk("alu_wr", 32'(WriteRegister1_OUT), 32'd5);
    nxt();
    // LB with three stalled cycles
    set_op(LB, 1'b1, 1'b0, 1'b1, 32'h103, 32'h0, 5'd7);
    dmem.dmem_rdata = 32'h80FF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("lb_stall", 32'(STALL_OUT), 32'd1);
      chk("lb_be", 32'(dmem.dmem_be), 32'b1000);
      if (i > 0) chk("lb_bubble", 32'(RegWrite1_OUT), 32'd0);
      nxt();
    end
    dmem.dmem_ack = 1'b1;
    @(negedge CLK);
    chk("lb_ack_stall", 32'(STALL_OUT), 32'd0);
    nxt();
    dmem.dmem_ack = 1'b0; nop();
    @(negedge CLK);
    chk("lb_wd", WriteData1_OUT, 32'hFFFF_FF80);
    chk("lb_rw", 32'(RegWrite1_OUT), 32'd1);
    nxt();
    // SH acknowledged in the same cycle
    set_op(SH, 1'b0, 1'b1, 1'b1, 32'h202, 32'h0000_ABCD, 5'd3);
    dmem.dmem_ack = 1'b1;
    @(negedge CLK);
    chk("sh_we", 32'(dmem.dmem_we), 32'd1);
    chk("sh_be", 32'(dmem.dmem_be), 32'b1100);
    chk("sh_wdata", dmem.dmem_wdata, 32'hABCD_ABCD);
    chk("sh_stall", 32'(STALL_OUT), 32'd0);
    nxt();
    dmem.dmem_ack = 1'b0; nop();
    @(negedge CLK);
    chk("sh_rw", 32'(RegWrite1_OUT), 32'd0);
    nxt();
    // misaligned LW
    set_op(LW, 1'b1, 1'b0, 1'b1, 32'h106, 32'h0, 5'd4);
    @(negedge CLK);
    chk("mis_req", 32'(dmem.dmem_req), 32'd0);
    chk("mis_stall", 32'(STALL_OUT), 32'd0);
    nxt();
    nop();
    @(negedge CLK);
    chk("mis_pulse", 32'(MisalignFault_OUT), 32'd1);
    chk("mis_rw", 32'(RegWrite1_OUT), 32'd0);
    nxt();
    @(negedge CLK);
    chk("mis_pulse_end", 32'(MisalignFault_OUT), 32'd0);
    nxt();
    // more loads and stores
    run_load(LBU, 32'h101, 32'h1234_ABCD, 0, 5'd10, 32'h0000_00AB);
    run_load(LH, 32'h102, 32'h8001_7777, 1, 5'd11, 32'hFFFF_8001);
    run_load(LW, 32'h108, 32'hCAFE_F00D, 2, 5'd12, 32'hCAFE_F00D);
    run_load(LB, 32'h100, 32'h0000_007F, 0, 5'd13, 32'h0000_007F);
    set_op(SB, 1'b0, 1'b1, 1'b1, 32'h3, 32'h0000_005A, 5'd1);
    dmem.dmem_ack = 1'b1;
    @(negedge CLK);
    chk("sb_wdata", dmem.dmem_wdata, 32'h5A5A_5A5A);
    nxt();
    set_op(SW, 1'b0, 1'b1, 1'b0, 32'h10, 32'h1122_3344, 5'd2);
    @(negedge CLK);
    chk("sw_be", 32'(dmem.dmem_be), 32'b1111);
    nxt();
    // ack with no memory op is ignored
    nop();
    @(negedge CLK);
    chk("idle_ack_stall", 32'(STALL_OUT), 32'd0);
    nxt();
    dmem.dmem_ack = 1'b0;
    // reset while waiting on a LW, then a late ack
    set_op(LW, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 5'd6);
    @(negedge CLK);
    chk("rw_wait_stall", 32'(STALL_OUT), 32'd1);
    nxt();
    RESET = 1'b0; nop();
    @(negedge CLK);
    chk("rw_rst_req", 32'(dmem.dmem_req), 32'd0);
    chk("rw_rst_stall", 32'(STALL_OUT), 32'd0);
    chk("rw_rst_instr", Instr1_OUT, 32'h0);
    nxt();
    RESET = 1'b1; dmem.dmem_ack = 1'b1;
    @(negedge CLK);
    chk("late_ack_req", 32'(dmem.dmem_req), 32'd0);
    chk("late_ack_fsm", 32'(dut.state), 32'(IDLE));
    nxt();
    dmem.dmem_ack = 1'b0;
    @(negedge CLK);
    chk("late_ack_rw", 32'(RegWrite1_OUT), 32'd0);
    nxt();
    // LHU that feeds the bypass path when enabled
    run_load(LHU, 32'h40, 32'h0000_F00D, 0, 5'd9, 32'h0000_F00D);
`ifdef MEM_FORWARDING_EN
    chk("byp_reg_lit", 32'(BypassReg1_MEMEXE), 32'd9);
    chk("byp_data_lit", BypassData1_MEMEXE, 32'h0000_F00D);
    chk("byp_valid_lit", 32'(BypassValid1_MEMEXE), 32'd1);
`endif
    nxt();
    nxt();
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
